// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared encodings for the floating-point hazard controller.
//   FWD_*   : operand forward-select codes driven onto ForwardAE/BE/CE
//   CLS_*   : register class tag carried with every register index
//   fpuState_t : states of the multi-cycle FPU hold FSM
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic CLS_INT = 1'b0;
    localparam logic CLS_FP  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fpuState_t;

    // Integer x0 is hardwired to zero and must never take part in a hazard;
    // FP f0 is an ordinary register and does.
    function automatic logic isHardZero(input logic isZeroIdx, input logic cls);
        return isZeroIdx && (cls != CLS_FP);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// ---------------------------------------------------------------------------
// hazard_fwd_sel
// Forward-select for one EX source operand. MEM wins over WB; a producer
// only matches when both index and register class agree.
// Ports:
//   i_rs, i_fs                     EX source index / class
//   i_rdM, i_fpRdM, i_regWriteM    MEM-stage destination
//   i_rdW, i_fpRdW, i_regWriteW    WB-stage destination
//   o_fwd                          FWD_RF / FWD_WB / FWD_MEM
// ---------------------------------------------------------------------------
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_fs,
    input  logic [REG_AW-1:0] i_rdM,
    input  logic              i_fpRdM,
    input  logic              i_regWriteM,
    input  logic [REG_AW-1:0] i_rdW,
    input  logic              i_fpRdW,
    input  logic              i_regWriteW,
    output logic [1:0]        o_fwd
);

    logic w_srcHardZero;
    logic w_matchM;
    logic w_matchW;

    assign w_srcHardZero = isHardZero(i_rs == '0, i_fs);
    assign w_matchM = (i_rs == i_rdM) && (i_fs == i_fpRdM) && !w_srcHardZero;
    assign w_matchW = (i_rs == i_rdW) && (i_fs == i_fpRdW) && !w_srcHardZero;

    always_comb begin
        o_fwd = FWD_RF;
        if (i_regWriteM && w_matchM) begin
            o_fwd = FWD_MEM;
        end else if (i_regWriteW && w_matchW) begin
            o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/fp_hazard_unit.sv
// ---------------------------------------------------------------------------
// fp_hazard_unit
// Hazard controller for the five-stage core with FP extension: three-operand
// forwarding across int/FP files, load-use stall (lw/flw), a hold FSM for
// multi-cycle FPU ops in EX, and flushing on taken control transfers.
// Ports:
//   clk, reset (sync, active low)
//   Rs{1,2,3}D/FpS{1,2,3}D   decode sources    Rs{1,2,3}E/FpS{1,2,3}E  EX sources
//   RdE/FpRdE, ResultSrcE     EX destination / load flag (bit0)
//   FpMultiE, PCSrcE          multi-cycle FP op in EX / taken branch in EX
//   RdM/FpRdM/RegWriteM, RdW/FpRdW/RegWriteW   MEM and WB producers
//   ForwardAE/BE/CE           operand selects
//   StallF/D/E, FlushD/E/M    pipeline register controls
//   FpuBusy                   hold FSM is in BUSY
//   LoadStallCnt, FpuStallCnt, FlushCnt   only with HAZARD_STATS_EN
// Optional feature macro: HAZARD_STATS_EN (saturating event counters).
// ---------------------------------------------------------------------------
module fp_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int FPU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs3D,
    input  logic              FpS1D,
    input  logic              FpS2D,
    input  logic              FpS3D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] Rs3E,
    input  logic              FpS1E,
    input  logic              FpS2E,
    input  logic              FpS3E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              FpRdE,
    input  logic [1:0]        ResultSrcE,
    input  logic              FpMultiE,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              FpRdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              FpRdW,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [1:0]        ForwardCE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0]  LoadStallCnt,
    output logic [CNT_W-1:0]  FpuStallCnt,
    output logic [CNT_W-1:0]  FlushCnt,
`endif
    output logic              FpuBusy
);

    // Counter only has to reach FPU_LAT-2; keep at least one bit so the
    // FPU_LAT <= 2 builds stay legal.
    localparam int CW = (FPU_LAT > 2) ? $clog2(FPU_LAT) : 1;
    localparam logic [CW-1:0] CNT_START = (FPU_LAT > 1) ? CW'(FPU_LAT - 2) : '0;
    localparam logic MULTI_CYCLE = (FPU_LAT > 1);

    fpuState_t      r_state;
    fpuState_t      w_nextState;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_nextCnt;
    logic           w_fpuStall;
    logic           w_lwStall;
    logic           w_unusedResultSrc;

    assign w_unusedResultSrc = ResultSrcE[1];

    // ---------------- forwarding ----------------
    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwdA (
        .i_rs(Rs1E), .i_fs(FpS1E),
        .i_rdM(RdM), .i_fpRdM(FpRdM), .i_regWriteM(RegWriteM),
        .i_rdW(RdW), .i_fpRdW(FpRdW), .i_regWriteW(RegWriteW),
        .o_fwd(ForwardAE)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwdB (
        .i_rs(Rs2E), .i_fs(FpS2E),
        .i_rdM(RdM), .i_fpRdM(FpRdM), .i_regWriteM(RegWriteM),
        .i_rdW(RdW), .i_fpRdW(FpRdW), .i_regWriteW(RegWriteW),
        .o_fwd(ForwardBE)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwdC (
        .i_rs(Rs3E), .i_fs(FpS3E),
        .i_rdM(RdM), .i_fpRdM(FpRdM), .i_regWriteM(RegWriteM),
        .i_rdW(RdW), .i_fpRdW(FpRdW), .i_regWriteW(RegWriteW),
        .o_fwd(ForwardCE)
    );

    // ---------------- load-use ----------------
    function automatic logic loadMatch(input logic [REG_AW-1:0] rs, input logic fs);
        return (rs == RdE) && (fs == FpRdE) && !isHardZero(rs == '0, fs);
    endfunction

    assign w_lwStall = ResultSrcE[0] &&
                       (loadMatch(Rs1D, FpS1D) || loadMatch(Rs2D, FpS2D) ||
                        loadMatch(Rs3D, FpS3D));

    // ---------------- FPU hold FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // In the release cycle (BUSY, cnt==0) FpMultiE still shows the finishing
    // op, so it is deliberately not looked at there.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (FpMultiE && MULTI_CYCLE) begin
                    w_nextState = BUSY;
                    w_nextCnt   = CNT_START;
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_nextCnt = r_cnt - CW'(1);
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase
    end

    always_comb begin
        w_fpuStall = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE:    w_fpuStall = FpMultiE && MULTI_CYCLE;
                BUSY:    w_fpuStall = (r_cnt != '0);
                default: w_fpuStall = 1'b0;
            endcase
        end
    end

    assign FpuBusy = (r_state == BUSY);

    // ---------------- stall / flush ----------------
    // A held EX slot cannot contain a branch, so PCSrcE is masked by the hold.
    assign StallF = w_lwStall | w_fpuStall;
    assign StallD = w_lwStall | w_fpuStall;
    assign StallE = w_fpuStall;
    assign FlushM = w_fpuStall;
    assign FlushE = (w_lwStall | PCSrcE) & ~w_fpuStall;
    assign FlushD = PCSrcE & ~w_fpuStall;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_loadStallCnt;
    logic [CNT_W-1:0] r_fpuStallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    // Saturating event counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_loadStallCnt <= '0;
            r_fpuStallCnt  <= '0;
            r_flushCnt     <= '0;
        end else begin
            if (w_lwStall && (r_loadStallCnt != '1))
                r_loadStallCnt <= r_loadStallCnt + CNT_W'(1);
            if (w_fpuStall && (r_fpuStallCnt != '1))
                r_fpuStallCnt <= r_fpuStallCnt + CNT_W'(1);
            if (PCSrcE && !w_fpuStall && (r_flushCnt != '1))
                r_flushCnt <= r_flushCnt + CNT_W'(1);
        end
    end

    assign LoadStallCnt = r_loadStallCnt;
    assign FpuStallCnt  = r_fpuStallCnt;
    assign FlushCnt     = r_flushCnt;
`else
    localparam int unusedCntW = CNT_W;
`endif

endmodule

// File: tb/tb_fp_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fp_hazard_unit
// Randomised and directed bench for fp_hazard_unit. A behavioural model
// tracks which cycle of a multi-cycle FP op occupies EX and derives every
// output from the hazard rules; directed cases pin literal values.
// Build with +define+HAZARD_STATS_EN to cover the statistics counters.
// ---------------------------------------------------------------------------
module tb_fp_hazard_unit;

    localparam int REG_AW  = 5;
    localparam int FPU_LAT = 4;
    localparam int CNT_W   = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs3D, Rs1E, Rs2E, Rs3E, RdE, RdM, RdW;
    logic              FpS1D, FpS2D, FpS3D, FpS1E, FpS2E, FpS3E;
    logic              FpRdE, FpRdM, FpRdW, RegWriteM, RegWriteW;
    logic [1:0]        ResultSrcE;
    logic              FpMultiE, PCSrcE;
    logic [1:0]        ForwardAE, ForwardBE, ForwardCE;
    logic              StallF, StallD, StallE, FlushD, FlushE, FlushM, FpuBusy;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0]  LoadStallCnt, FpuStallCnt, FlushCnt;
`endif

    int     checks = 0;
    int     errors = 0;
    bit     checkEnable = 1'b0;
    int     modelPrevK = 0;
    longint modelLoadCnt = 0;
    longint modelFpuCnt = 0;
    longint modelFlushCnt = 0;
    longint cntMax = (longint'(1) << CNT_W) - 1;

    fp_hazard_unit #(.REG_AW(REG_AW), .FPU_LAT(FPU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs3D(Rs3D),
        .FpS1D(FpS1D), .FpS2D(FpS2D), .FpS3D(FpS3D),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs3E(Rs3E),
        .FpS1E(FpS1E), .FpS2E(FpS2E), .FpS3E(FpS3E),
        .RdE(RdE), .FpRdE(FpRdE), .ResultSrcE(ResultSrcE),
        .FpMultiE(FpMultiE), .PCSrcE(PCSrcE),
        .RdM(RdM), .FpRdM(FpRdM), .RegWriteM(RegWriteM),
        .RdW(RdW), .FpRdW(FpRdW), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardCE(ForwardCE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
`ifdef HAZARD_STATS_EN
        .LoadStallCnt(LoadStallCnt), .FpuStallCnt(FpuStallCnt), .FlushCnt(FlushCnt),
`endif
        .FpuBusy(FpuBusy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic refMatch(input logic [REG_AW-1:0] rs, input logic fs,
                                      input logic [REG_AW-1:0] rd, input logic frd);
        return (rs == rd) && (fs == frd) && !(fs == 1'b0 && rs == '0);
    endfunction

    function automatic logic [1:0] refFwd(input logic [REG_AW-1:0] rs, input logic fs);
        if (RegWriteM && refMatch(rs, fs, RdM, FpRdM)) return 2'b10;
        if (RegWriteW && refMatch(rs, fs, RdW, FpRdW)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic refLw();
        return ResultSrcE[0] && (refMatch(Rs1D, FpS1D, RdE, FpRdE) ||
                                 refMatch(Rs2D, FpS2D, RdE, FpRdE) ||
                                 refMatch(Rs3D, FpS3D, RdE, FpRdE));
    endfunction

    // Position (1..FPU_LAT) of the current cycle within a multi-cycle op, 0 if none.
    function automatic int opPosition(input int prevK, input logic multi);
        if (prevK >= 1 && prevK < FPU_LAT) return prevK + 1;
        if (multi && FPU_LAT > 1) return 1;
        return 0;
    endfunction

    function automatic logic refFpuStall(input int k);
        return reset && (k >= 1) && (k < FPU_LAT);
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        int  k;
        logic stall;
        if (!reset) begin
            modelPrevK    = 0;
            modelLoadCnt  = 0;
            modelFpuCnt   = 0;
            modelFlushCnt = 0;
            checkEnable   = 1'b1;
        end else begin
            k = opPosition(modelPrevK, FpMultiE);
            stall = refFpuStall(k);
            if (refLw() && modelLoadCnt < cntMax) modelLoadCnt++;
            if (stall && modelFpuCnt < cntMax) modelFpuCnt++;
            if (PCSrcE && !stall && modelFlushCnt < cntMax) modelFlushCnt++;
            modelPrevK = k;
        end
    end

    always @(negedge clk) begin
        int   k;
        logic stall, lw;
        if (checkEnable) begin
            k = opPosition(modelPrevK, FpMultiE);
            stall = refFpuStall(k);
            lw = refLw();
            checkOutput("ForwardAE", ForwardAE, refFwd(Rs1E, FpS1E));
            checkOutput("ForwardBE", ForwardBE, refFwd(Rs2E, FpS2E));
            checkOutput("ForwardCE", ForwardCE, refFwd(Rs3E, FpS3E));
            checkOutput("StallF", StallF, lw | stall);
            checkOutput("StallD", StallD, lw | stall);
            checkOutput("StallE", StallE, stall);
            checkOutput("FlushM", FlushM, stall);
            checkOutput("FlushE", FlushE, (lw | PCSrcE) & !stall);
            checkOutput("FlushD", FlushD, PCSrcE & !stall);
            checkOutput("FpuBusy", FpuBusy, k >= 2);
`ifdef HAZARD_STATS_EN
            checkOutput("LoadStallCnt", LoadStallCnt, modelLoadCnt);
            checkOutput("FpuStallCnt", FpuStallCnt, modelFpuCnt);
            checkOutput("FlushCnt", FlushCnt, modelFlushCnt);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic clearInputs();
        reset = 1'b1;
        {Rs1D, Rs2D, Rs3D, Rs1E, Rs2E, Rs3E, RdE, RdM, RdW} = '0;
        {FpS1D, FpS2D, FpS3D, FpS1E, FpS2E, FpS3E} = '0;
        {FpRdE, FpRdM, FpRdW, RegWriteM, RegWriteW, FpMultiE, PCSrcE} = '0;
        ResultSrcE = 2'b00;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        Rs1D = REG_AW'($urandom_range(0, 3));
        Rs2D = REG_AW'($urandom_range(0, 3));
        Rs3D = REG_AW'($urandom_range(0, 3));
        Rs1E = REG_AW'($urandom_range(0, 3));
        Rs2E = REG_AW'($urandom_range(0, 3));
        Rs3E = REG_AW'($urandom_range(0, 3));
        RdE  = REG_AW'($urandom_range(0, 3));
        RdM  = REG_AW'($urandom_range(0, 3));
        RdW  = REG_AW'($urandom_range(0, 3));
        {FpS1D, FpS2D, FpS3D, FpS1E, FpS2E, FpS3E} = 6'($urandom);
        {FpRdE, FpRdM, FpRdW, RegWriteM, RegWriteW} = 5'($urandom);
        ResultSrcE = 2'($urandom);
        FpMultiE = ($urandom_range(0, 3) == 0);
        PCSrcE   = ($urandom_range(0, 4) == 0);
        reset    = ($urandom_range(0, 39) != 0);
    endtask

    initial begin
        clearInputs();
        reset = 1'b0;
        FpMultiE = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("resetStallE", StallE, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("resetBusy", FpuBusy, 1'b0);
        checkOutput("resetStallF", StallF, 1'b0);

        // MEM beats WB
        nextCycle();
        clearInputs();
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        @(negedge clk);
        checkOutput("planFwdMemPrio", ForwardAE, 2'b10);

        // x0 never forwards, f0 does
        nextCycle();
        clearInputs();
        Rs2E = 0; RdM = 0; RegWriteM = 1;
        @(negedge clk);
        checkOutput("planFwdX0", ForwardBE, 2'b00);
        nextCycle();
        FpS2E = 1; FpRdM = 1;
        @(negedge clk);
        checkOutput("planFwdF0", ForwardBE, 2'b10);

        // class mismatch blocks forwarding; same-class WB still forwards
        nextCycle();
        clearInputs();
        RdM = 3; RegWriteM = 1; Rs3E = 3; FpS3E = 1;
        @(negedge clk);
        checkOutput("planFwdClass", ForwardCE, 2'b00);
        nextCycle();
        RdW = 3; FpRdW = 1; RegWriteW = 1;
        @(negedge clk);
        checkOutput("planFwdWb", ForwardCE, 2'b01);

        // flw f4 in EX with f4 in decode
        nextCycle();
        clearInputs();
        ResultSrcE = 2'b01; RdE = 4; FpRdE = 1; Rs3D = 4; FpS3D = 1;
        @(negedge clk);
        checkOutput("planLwStallF", StallF, 1'b1);
        checkOutput("planLwStallD", StallD, 1'b1);
        checkOutput("planLwFlushE", FlushE, 1'b1);
        checkOutput("planLwStallE", StallE, 1'b0);
        nextCycle();
        ResultSrcE = 2'b00;
        @(negedge clk);
        checkOutput("planLwRelease", StallF, 1'b0);

        // four-cycle FP op with a branch in cycle 2
        nextCycle();
        clearInputs();
        FpMultiE = 1;
        for (int c = 1; c <= 4; c++) begin
            PCSrcE = (c == 2);
            @(negedge clk);
            checkOutput($sformatf("planFpuStallE%0d", c), StallE, c < 4);
            checkOutput($sformatf("planFpuFlushM%0d", c), FlushM, c < 4);
            checkOutput($sformatf("planFpuBusy%0d", c), FpuBusy, c > 1);
            if (c == 2) checkOutput("planFpuFlushD", FlushD, 1'b0);
            nextCycle();
        end
        clearInputs();
        @(negedge clk);
        checkOutput("planFpuIdle", FpuBusy, 1'b0);

        // reset during BUSY aborts the op
        nextCycle();
        FpMultiE = 1;
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("planRstMidBusy", FpuBusy, 1'b1);
        checkOutput("planRstMidStall", StallE, 1'b0);
        nextCycle();
        clearInputs();
        @(negedge clk);
        checkOutput("planRstAbortBusy", FpuBusy, 1'b0);
        checkOutput("planRstAbortStall", StallE, 1'b0);
`ifdef HAZARD_STATS_EN
        checkOutput("planRstLoadCnt", LoadStallCnt, 0);
        checkOutput("planRstFpuCnt", FpuStallCnt, 0);
        checkOutput("planRstFlushCnt", FlushCnt, 0);
`endif

        // random phase, compared every cycle by the model process
        for (int i = 0; i < 3000; i++) begin
            nextCycle();
            applyStimulus();
        end
        nextCycle();
        clearInputs();
        repeat (FPU_LAT + 1) nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
